alu_arbiter: RTL

- Shares the single tiny16 ALU between NUM_REQ requesters, e.g. the execute stage and the address-generation unit.
- Per-requester valid/ready request handshake; round-robin arbitration.
- Sequences one ALU operation at a time: drives opcode/operands with out_en, captures the result and the registered O C N Z flags.
- Returns result and flags to the winning requester over a valid/ready response handshake.

---
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one tiny16 ALU between NUM_REQ requesters.
// Optional macro ALU_DIV_GUARD_EN: suppress divide-by-zero and flag it on resp_err.
module alu_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [4*NUM_REQ-1:0]       req_opcode,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_src1,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_src2,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_result,
    output logic [3:0]                 resp_flags,
    output logic                       resp_err,
    output logic [3:0]                 alu_opcode,
    output logic [DATA_WIDTH-1:0]      alu_src1,
    output logic [DATA_WIDTH-1:0]      alu_src2,
    output logic                       alu_out_en,
    input  logic [DATA_WIDTH-1:0]      alu_out,
    input  logic [3:0]                 alu_flags
);

    localparam int unsigned IdxW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic [IdxW-1:0]       owner_q, owner_d;
    logic [3:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d;
    logic [DATA_WIDTH-1:0] src2_q, src2_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [3:0]            flags_q, flags_d;
    logic                  err_q, err_d;

    logic                  found;
    logic [IdxW-1:0]       winner;
    logic [IdxW-1:0]       cand;
    logic                  div_zero;

`ifdef ALU_DIV_GUARD_EN
    assign div_zero = (op_q == 4'b0011) && (src2_q == '0);
`else
    assign div_zero = 1'b0;
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IdxW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Search starts one past the last winner and wraps.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        result_d   = result_q;
        flags_d    = flags_q;
        err_d      = err_q;
        req_ready  = '0;
        resp_valid = '0;
        alu_out_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready = rst ? '0 : onehot(winner);
                    ptr_d     = winner;
                    owner_d   = winner;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (32'(winner) == i) begin
                            op_d   = req_opcode[4*i +: 4];
                            src1_d = req_src1[DATA_WIDTH*i +: DATA_WIDTH];
                            src2_d = req_src2[DATA_WIDTH*i +: DATA_WIDTH];
                        end
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                alu_out_en = !div_zero;
                result_d   = div_zero ? '1 : alu_out;
                err_d      = div_zero;
                state_d    = StCapture;
            end
            StCapture: begin
                // ALU flags are registered, so they are only valid one cycle after out_en.
                flags_d = div_zero ? 4'b0000 : alu_flags;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = onehot(owner_q);
                if (resp_ready[owner_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= IdxW'(NUM_REQ - 1);
            owner_q  <= '0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign alu_opcode  = op_q;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
    assign resp_result = result_q;
    assign resp_flags  = flags_q;
    assign resp_err    = err_q;

endmodule
